// File: rtl/product_readout_if.sv
// Handshake/bus bundle for product_readout: start request, product array in, row beats out.
interface product_readout_if #(
    parameter int DIM_C     = 16,
    parameter int DIM_A     = 32,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16,
    parameter int ROW_W     = (DIM_C > 1) ? $clog2(DIM_C) : 1
) ();
    logic                                       start;
    logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] prod_in;
    logic                                       busy;
    logic                                       out_valid;
    logic                                       out_ready;
    logic [DIM_A-1:0][OUT_WIDTH-1:0]            out_data;
    logic [ROW_W-1:0]                           out_row;
    logic                                       out_last;
    logic                                       sat;
    logic                                       done;

    modport master (
        output start, prod_in, out_ready,
        input  busy, out_valid, out_data, out_row, out_last, sat, done
    );

    modport slave (
        input  start, prod_in, out_ready,
        output busy, out_valid, out_data, out_row, out_last, sat, done
    );
endinterface

// File: rtl/product_readout.sv
// Snapshots a product array on start and drains it one row per beat with valid/ready.
// Element conversion: saturation when READOUT_SAT_EN is defined, truncation otherwise.
module product_readout #(
    parameter int DIM_C     = 16,
    parameter int DIM_A     = 32,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16,
    parameter int ROW_W     = (DIM_C > 1) ? $clog2(DIM_C) : 1
) (
    input  logic             clk,
    input  logic             rst,
    product_readout_if.slave rd_if
);
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DIM_C - 1);

    state_e                                     state_q, state_d;
    logic [ROW_W-1:0]                           row_q, row_d;
    logic                                       done_q, done_d;
    logic                                       snap_load_s;
    logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] snap_q;
    logic [DIM_A-1:0][ACC_WIDTH-1:0]            row_s;
    logic [DIM_A-1:0][OUT_WIDTH-1:0]            conv_s;
    logic [DIM_A-1:0]                           clip_s;
    logic                                       stream_s;

    assign stream_s = (state_q == STREAM);
    assign row_s    = snap_q[row_q];

    // State, row counter and done pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    // Snapshot storage; contents after reset are irrelevant so it carries no reset
    always_ff @(posedge clk) begin
        if (snap_load_s) begin
            snap_q <= rd_if.prod_in;
        end else begin
            snap_q <= snap_q;
        end
    end

    // Next-state logic: accept start in IDLE, advance one row per completed beat
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        done_d      = 1'b0;
        snap_load_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_if.start) begin
                    state_d     = STREAM;
                    row_d       = '0;
                    snap_load_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (rd_if.out_ready) begin
                    if (row_q == LAST_ROW) begin
                        state_d = IDLE;
                        row_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end else begin
                    row_d = row_q;
                end
            end
            default: begin
                state_d = IDLE;
                row_d   = '0;
            end
        endcase
    end

`ifdef READOUT_SAT_EN
    localparam int EXT_W = ACC_WIDTH - OUT_WIDTH + 1;
    localparam logic signed [ACC_WIDTH-1:0] MAX_C = {{EXT_W{1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_C = {{EXT_W{1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // Returns {clip flag, clamped element}
    function automatic logic [OUT_WIDTH:0] sat_elem(input logic signed [ACC_WIDTH-1:0] e);
        logic [OUT_WIDTH:0] r;
        if (e > MAX_C) begin
            r = {1'b1, MAX_C[OUT_WIDTH-1:0]};
        end else if (e < MIN_C) begin
            r = {1'b1, MIN_C[OUT_WIDTH-1:0]};
        end else begin
            r = {1'b0, e[OUT_WIDTH-1:0]};
        end
        return r;
    endfunction

    // Per-element saturation of the displayed row
    always_comb begin
        conv_s = '0;
        clip_s = '0;
        for (int i = 0; i < DIM_A; i++) begin
            {clip_s[i], conv_s[i]} = sat_elem(row_s[i]);
        end
    end
`else
    logic unused_row_s;
    assign unused_row_s = ^row_s;
    assign clip_s       = '0;

    // Per-element truncation of the displayed row
    always_comb begin
        conv_s = '0;
        for (int i = 0; i < DIM_A; i++) begin
            conv_s[i] = row_s[i][OUT_WIDTH-1:0];
        end
    end
`endif

    // Beat fields are gated by STREAM so every output reads zero in IDLE and reset
    assign rd_if.busy      = stream_s;
    assign rd_if.out_valid = stream_s;
    assign rd_if.out_row   = row_q;
    assign rd_if.out_last  = stream_s && (row_q == LAST_ROW);
    assign rd_if.sat       = stream_s && (|clip_s);
    assign rd_if.out_data  = stream_s ? conv_s : '0;
    assign rd_if.done      = done_q;
endmodule

// File: tb/tb_product_readout.sv
// Self-checking bench for product_readout: conversion table, drains with backpressure,
// snapshot isolation, random data against an arithmetic reference model, reset mid-drain.
module tb_product_readout;
    localparam int DC = 16;
    localparam int DA = 32;
    localparam int AW = 32;
    localparam int OW = 16;

    typedef logic [DC-1:0][DA-1:0][AW-1:0] prod_t;
    typedef logic [DA-1:0][OW-1:0]         row_out_t;

    typedef struct {
        logic [AW-1:0] v0, v1, v2, fill;
        logic [OW-1:0] e0, e1, e2, efill;
        logic          esat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    product_readout_if #(.DIM_C(DC), .DIM_A(DA), .ACC_WIDTH(AW), .OUT_WIDTH(OW)) rd_if ();

    product_readout #(.DIM_C(DC), .DIM_A(DA), .ACC_WIDTH(AW), .OUT_WIDTH(OW)) dut (
        .clk   (clk),
        .rst   (rst),
        .rd_if (rd_if)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input row_out_t act, input row_out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference conversion from signed arithmetic on the element value
    function automatic logic [OW-1:0] conv(input logic [AW-1:0] e);
        longint v;
        v = longint'($signed(e));
`ifdef READOUT_SAT_EN
        if (v > (longint'(1) <<< (OW - 1)) - 1) v = (longint'(1) <<< (OW - 1)) - 1;
        else if (v < -(longint'(1) <<< (OW - 1))) v = -(longint'(1) <<< (OW - 1));
`endif
        return OW'(v);
    endfunction

    function automatic logic clipped(input logic [AW-1:0] e);
`ifdef READOUT_SAT_EN
        longint v;
        v = longint'($signed(e));
        return (v > (longint'(1) <<< (OW - 1)) - 1) || (v < -(longint'(1) <<< (OW - 1)));
`else
        return (e === 'x);
`endif
    endfunction

    function automatic row_out_t model_row(input prod_t p, input int r);
        row_out_t o;
        for (int a = 0; a < DA; a++) o[a] = conv(p[r][a]);
        return o;
    endfunction

    function automatic logic model_sat(input prod_t p, input int r);
        logic s;
        s = 1'b0;
        for (int a = 0; a < DA; a++) s = s | clipped(p[r][a]);
        return s;
    endfunction

    function automatic prod_t rand_prod();
        prod_t p;
        int    s;
        for (int r = 0; r < DC; r++) begin
            for (int a = 0; a < DA; a++) begin
                case ($urandom_range(0, 2))
                    0: p[r][a] = $urandom();
                    1: begin
                        s = int'($urandom_range(0, 80000)) - 40000;
                        p[r][a] = s;
                    end
                    default: p[r][a] = 32'($urandom_range(0, 32767));
                endcase
            end
        end
        return p;
    endfunction

    function automatic prod_t basic_prod();
        prod_t p;
        for (int r = 0; r < DC; r++)
            for (int a = 0; a < DA; a++) p[r][a] = 32'(r * 100 + a);
        return p;
    endfunction

    task automatic check_beat(input prod_t snap, input int r);
        chk1($sformatf("busy_r%0d", r), rd_if.busy, 1'b1);
        chk1($sformatf("valid_r%0d", r), rd_if.out_valid, 1'b1);
        chkn($sformatf("row_r%0d", r), 32'(rd_if.out_row), 32'(r));
        chk1($sformatf("last_r%0d", r), rd_if.out_last, (r == DC - 1));
        chk1($sformatf("sat_r%0d", r), rd_if.sat, model_sat(snap, r));
        chkd($sformatf("data_r%0d", r), rd_if.out_data, model_row(snap, r));
    endtask

    task automatic check_idle_zero(input string tag);
        chk1({tag, "_busy"}, rd_if.busy, 1'b0);
        chk1({tag, "_valid"}, rd_if.out_valid, 1'b0);
        chk1({tag, "_last"}, rd_if.out_last, 1'b0);
        chk1({tag, "_sat"}, rd_if.sat, 1'b0);
        chk1({tag, "_done"}, rd_if.done, 1'b0);
        chkn({tag, "_row"}, 32'(rd_if.out_row), 32'd0);
        chkd({tag, "_data"}, rd_if.out_data, '0);
    endtask

    // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic run_drain(input prod_t p, input int mode, input bit perturb,
                             input bit extra_start, input int abort_beats);
        prod_t snap;
        int    row, cyc;
        logic  rdy;
        rd_if.prod_in   = p;
        snap            = p;
        rd_if.start     = 1'b1;
        rd_if.out_ready = 1'b1;
        @(posedge clk); #1;
        rd_if.start = 1'b0;
        row = 0;
        cyc = 0;
        while (row < DC && cyc < 400) begin
            check_beat(snap, row);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            rd_if.out_ready = rdy;
            if (perturb) rd_if.prod_in = rand_prod();
            if (extra_start) rd_if.start = (cyc >= 1 && cyc <= 3);
            @(posedge clk); #1;
            if (rdy) row++;
            cyc++;
            if (abort_beats > 0 && row == abort_beats) begin
                rd_if.start = 1'b0;
                rst = 1'b1;
                #1;
                check_idle_zero("abort_async");
                repeat (2) begin
                    @(posedge clk); #1;
                    chk1("abort_no_done", rd_if.done, 1'b0);
                end
                rst = 1'b0;
                @(posedge clk); #1;
                check_idle_zero("abort_released");
                return;
            end
        end
        rd_if.start = 1'b0;
        chkn("drain_beats", 32'(row), 32'(DC));
        chk1("done_pulse", rd_if.done, 1'b1);
        chk1("done_valid_low", rd_if.out_valid, 1'b0);
        chk1("done_busy_low", rd_if.busy, 1'b0);
    endtask

    vec_t  vt[4];
    prod_t p;

    initial begin
`ifdef READOUT_SAT_EN
        vt[0] = '{32'd40000, 32'hFFFF63C0, 32'd5, 32'd0, 16'h7FFF, 16'h8000, 16'd5, 16'd0, 1'b1};
        vt[1] = '{32'd7, 32'd7, 32'd7, 32'd7, 16'd7, 16'd7, 16'd7, 16'd7, 1'b0};
        vt[2] = '{32'h00007FFF, 32'hFFFF8000, 32'h00008000, 32'hFFFF7FFF,
                  16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 1'b1};
        vt[3] = '{32'h00018001, 32'd0, 32'd0, 32'hFFFFFFFF, 16'h7FFF, 16'd0, 16'd0, 16'hFFFF, 1'b1};
`else
        vt[0] = '{32'd40000, 32'hFFFF63C0, 32'd5, 32'd0, 16'h9C40, 16'h63C0, 16'd5, 16'd0, 1'b0};
        vt[1] = '{32'd7, 32'd7, 32'd7, 32'd7, 16'd7, 16'd7, 16'd7, 16'd7, 1'b0};
        vt[2] = '{32'h00007FFF, 32'hFFFF8000, 32'h00008000, 32'hFFFF7FFF,
                  16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 1'b0};
        vt[3] = '{32'h00018001, 32'd0, 32'd0, 32'hFFFFFFFF, 16'h8001, 16'd0, 16'd0, 16'hFFFF, 1'b0};
`endif
        rst             = 1'b1;
        rd_if.start     = 1'b0;
        rd_if.out_ready = 1'b0;
        rd_if.prod_in   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_zero("post_reset");

        // Conversion table: first beat is held stalled while compared, then drained
        for (int i = 0; i < 4; i++) begin
            p = '0;
            for (int a = 0; a < DA; a++) p[0][a] = vt[i].fill;
            p[0][0] = vt[i].v0;
            p[0][1] = vt[i].v1;
            p[0][2] = vt[i].v2;
            rd_if.prod_in   = p;
            rd_if.start     = 1'b1;
            rd_if.out_ready = 1'b0;
            @(posedge clk); #1;
            rd_if.start = 1'b0;
            @(posedge clk); #1;
            chk1($sformatf("vec%0d_valid", i), rd_if.out_valid, 1'b1);
            chkn($sformatf("vec%0d_e0", i), 32'(rd_if.out_data[0]), 32'(vt[i].e0));
            chkn($sformatf("vec%0d_e1", i), 32'(rd_if.out_data[1]), 32'(vt[i].e1));
            chkn($sformatf("vec%0d_e2", i), 32'(rd_if.out_data[2]), 32'(vt[i].e2));
            chkn($sformatf("vec%0d_efill", i), 32'(rd_if.out_data[DA-1]), 32'(vt[i].efill));
            chk1($sformatf("vec%0d_sat", i), rd_if.sat, vt[i].esat);
            rd_if.out_ready = 1'b1;
            repeat (DC) @(posedge clk);
            #1;
            chk1($sformatf("vec%0d_done", i), rd_if.done, 1'b1);
        end

        // Basic drain, started in the done cycle of the previous drain
        run_drain(basic_prod(), 0, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        chk1("done_one_cycle", rd_if.done, 1'b0);
        chk1("idle_after_done", rd_if.out_valid, 1'b0);

        // Backpressure, then back-to-back isolation drain with extra starts
        run_drain(rand_prod(), 1, 1'b0, 1'b0, 0);
        run_drain(rand_prod(), 0, 1'b1, 1'b1, 0);
        @(posedge clk); #1;
        chk1("extra_start_ignored", rd_if.out_valid, 1'b0);

        for (int k = 0; k < 3; k++) run_drain(rand_prod(), 2, 1'b1, 1'b0, 0);

        // Reset after five beats, then a full drain again
        run_drain(basic_prod(), 0, 1'b0, 1'b0, 5);
        run_drain(basic_prod(), 2, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/product_readout.md
PRODUCT_READOUT -- requirements
Module: product_readout

Interface
REQ-001 Parameter DIM_C, default 16, number of product rows.
REQ-002 Parameter DIM_A, default 32, number of elements per row.
REQ-003 Parameter ACC_WIDTH, default 32, signed accumulator element width.
REQ-004 Parameter OUT_WIDTH, default 16, signed output element width; OUT_WIDTH <= ACC_WIDTH.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  request to snapshot and drain the product array.
REQ-008 prod_in  input  DIM_C x DIM_A x ACC_WIDTH  product array, packed [row][elem][bit].
REQ-009 busy  output  1  high from the cycle after an accepted start until the last row is accepted.
REQ-010 out_valid  output  1  row beat valid.
REQ-011 out_ready  input  1  downstream accepts the beat.
REQ-012 out_data  output  DIM_A x OUT_WIDTH  converted row elements, packed [elem][bit].
REQ-013 out_row  output  clog2(DIM_C)  index of the row on out_data.
REQ-014 out_last  output  1  high with the beat for row DIM_C-1.
REQ-015 sat  output  1  high with a beat in which at least one element was clipped.
REQ-016 done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-017 FSM states: IDLE and STREAM.
REQ-018 IDLE with start=1 at edge N: copy prod_in into an internal snapshot, set row counter to 0, move to STREAM, and assert busy and out_valid from cycle N+1.
REQ-019 start is ignored in STREAM; the snapshot does not change while busy.
REQ-020 Later changes on prod_in do not affect the beats of a drain in progress.
REQ-021 A beat completes at an edge where out_valid=1 and out_ready=1.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_row, out_last and sat hold stable.
REQ-023 out_valid does not drop until its beat completes.
REQ-024 Throughput is one row per cycle while out_ready is held high.
REQ-025 A drain therefore takes DIM_C cycles from the first out_valid to the last beat.
REQ-026 Rows are emitted in order 0 to DIM_C-1; out_row equals the row counter.
REQ-027 When the beat with out_last=1 completes, go to IDLE; the next cycle has out_valid=0, busy=0 and done=1.
REQ-028 A start asserted in the done cycle is accepted, so back-to-back drains are allowed.
REQ-029 Element conversion is purely combinational from the snapshot row, so beats add no extra latency.
REQ-030 If DIM_C=1, the first beat has out_last=1.

Reset
REQ-031 On rst=1, asynchronously go to IDLE and clear the row counter.
REQ-032 Reset values: busy=0, out_valid=0, out_last=0, sat=0, done=0, out_row=0, out_data=0.
REQ-033 The snapshot contents after reset are don't-care.
REQ-034 Reset during STREAM abandons the drain; no done pulse is produced.
REQ-035 After rst is released, the first start is accepted normally.

Configuration
REQ-036 Macro READOUT_SAT_EN selects the element conversion.
REQ-037 READOUT_SAT_EN defined: each signed element above 2^(OUT_WIDTH-1)-1 becomes that maximum.
REQ-038 READOUT_SAT_EN defined: each signed element below -2^(OUT_WIDTH-1) becomes that minimum.
REQ-039 READOUT_SAT_EN defined: all other elements pass through unchanged, and sat is the OR of the per-element clip flags for the row shown.
REQ-040 READOUT_SAT_EN undefined: each element is its low OUT_WIDTH bits (truncation) and sat is tied to 0.

Verification
REQ-041 Basic drain: row r elem a = r*100+a, out_ready=1, single start; expect DIM_C consecutive beats, out_row 0..15, out_last only on row 15, done exactly 1 cycle later.
REQ-042 Backpressure: out_ready toggles 1,0,0,1 repeating; out_data stable across stalls, no row skipped or duplicated, 16 beats total.
REQ-043 Snapshot isolation: change prod_in every cycle after start, and assert start again during STREAM; every beat matches the snapshot taken at start, and the extra start is ignored.
REQ-044 Saturation with READOUT_SAT_EN: row 0 elements 40000, -40000, 5; expect 32767, -32768, 5 and sat=1; a row with all elements equal to 7 gives sat=0.
REQ-045 Truncation without READOUT_SAT_EN: element 0x0001_8001; expect 0x8001 and sat=0.
REQ-046 Reset mid-drain: assert rst after 5 beats; all outputs zero immediately, no done pulse; a new start after release drains rows 0..15 again.
